// File: rtl/matmul_pcpi_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_pcpi_seq_if
//  Brief    : PCPI coprocessor handshake bundle between CPU core and the
//             2x2 nibble matrix-multiply coprocessor.
//  Revision : 1.0 - initial release
// ============================================================================
interface matmul_pcpi_seq_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;

  // CPU side: issues requests, observes completion
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd
  );

  // Coprocessor side: consumes requests, reports completion
  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd
  );
endinterface
`default_nettype wire

// File: rtl/matmul_pcpi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_pcpi_seq
//  Brief    : PCPI coprocessor computing C = A x B for 2x2 matrices of 4-bit
//             unsigned elements, one product per cycle on a shared external
//             4x4 multiplier; each 8-bit result element saturates at 255.
//  Revision : 1.0 - initial release
// ============================================================================
module matmul_pcpi_seq #(
  parameter logic [6:0] OPCODE = 7'b0001011,
  parameter logic [6:0] FUNCT7 = 7'b0000001
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  matmul_pcpi_seq_if.slave    bus,
  output logic [3:0]          mul_a,
  output logic [3:0]          mul_b,
  input  wire logic [7:0]     mul_p
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_k;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [8:0]  r_acc;
  logic [31:0] r_c;
  logic [31:0] r_rd;

  logic        w_match;
  logic        w_start;
  logic [8:0]  w_sum;
  logic [7:0]  w_sat;
  logic [31:0] w_c_next;
  logic        w_wait;
  logic        w_ready;
  logic [3:0]  w_mul_a;
  logic [3:0]  w_mul_b;
  logic        w_unused;

  // Instruction decode: custom opcode, funct3 zero, configured funct7
  assign w_match = (bus.pcpi_insn[6:0]   == OPCODE) &&
                   (bus.pcpi_insn[14:12] == 3'b000) &&
                   (bus.pcpi_insn[31:25] == FUNCT7);
  assign w_start = bus.pcpi_valid && w_match;

  // Second partial product of an element: add and clamp to 8 bits
  assign w_sum = r_acc + {1'b0, mul_p};
  assign w_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

  // Result matrix with the element addressed by (i,j)=(k[2],k[1]) replaced
  always_comb begin
    w_c_next = r_c;
    w_c_next[{r_k[2], r_k[1], 3'b000} +: 8] = w_sat;
  end

  // Next-state logic and handshake / multiplier operand outputs
  always_comb begin
    w_next  = r_state;
    w_wait  = 1'b0;
    w_ready = 1'b0;
    w_mul_a = 4'd0;
    w_mul_b = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_MUL;
      end
      S_MUL: begin
        w_wait  = 1'b1;
        // A[i][t] lives at nibble 2i+t, B[t][j] at nibble 2t+j
        w_mul_a = r_a[{r_k[2], r_k[0], 2'b00} +: 4];
        w_mul_b = r_b[{r_k[0], r_k[1], 2'b00} +: 4];
        if (r_k == 3'd7) w_next = S_DONE;
      end
      S_DONE: begin
        w_ready = 1'b1;
        // Park in HOLD until the CPU withdraws the request so it is
        // never accepted twice.
        w_next  = bus.pcpi_valid ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!bus.pcpi_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand capture, step counter, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k   <= 3'd0;
      r_a   <= 16'd0;
      r_b   <= 16'd0;
      r_acc <= 9'd0;
      r_c   <= 32'd0;
      r_rd  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a <= bus.pcpi_rs1[15:0];
            r_b <= bus.pcpi_rs2[15:0];
            r_k <= 3'd0;
          end
        end
        S_MUL: begin
          r_k <= r_k + 3'd1;
          if (!r_k[0]) begin
            r_acc <= {1'b0, mul_p};
          end else begin
            r_c <= w_c_next;
            // Publish the finished matrix as DONE begins; the output then
            // stays put until the next request completes.
            if (r_k == 3'd7) r_rd <= w_c_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pcpi_wait  = w_wait;
  assign bus.pcpi_ready = w_ready;
  assign bus.pcpi_wr    = w_ready;
  assign bus.pcpi_rd    = r_rd;
  assign mul_a          = w_mul_a;
  assign mul_b          = w_mul_b;

  // Instruction fields and operand bits the datapath does not consume
  assign w_unused = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7],
                      bus.pcpi_rs1[31:16], bus.pcpi_rs2[31:16]};

endmodule
`default_nettype wire

// File: tb/tb_matmul_pcpi_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_pcpi_seq
//  Brief    : Directed self-checking bench for matmul_pcpi_seq with a
//             scoreboard of expected results and a behavioural multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_pcpi_seq;

  localparam logic [6:0]  C_OPCODE   = 7'b0001011;
  localparam logic [6:0]  C_FUNCT7   = 7'b0000001;
  localparam logic [31:0] C_INSN_OK  = {C_FUNCT7, 5'd2, 5'd1, 3'b000, 5'd3, C_OPCODE};
  localparam logic [31:0] C_INSN_OP  = {C_FUNCT7, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] C_INSN_F7  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, C_OPCODE};

  logic       clk;
  logic       rst_n;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_p;

  matmul_pcpi_seq_if bus ();

  matmul_pcpi_seq #(
    .OPCODE (C_OPCODE),
    .FUNCT7 (C_FUNCT7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p)
  );

  // Shared combinational 4x4 multiplier seen by the coprocessor
  assign mul_p = mul_a * mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd = 32'd0;
  int          exp_ma[8] = '{1, 2, 1, 2, 3, 4, 3, 4};
  int          exp_mb[8] = '{5, 7, 6, 8, 5, 7, 6, 8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 2x2 product with 8-bit saturation
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] res;
    int s;
    res = 32'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = int'(a[8*i +: 4]) * int'(b[4*j +: 4]) +
            int'(a[8*i+4 +: 4]) * int'(b[8+4*j +: 4]);
        res[16*i+8*j +: 8] = (s > 255) ? 8'hFF : 8'(s);
      end
    end
    return res;
  endfunction

  // Issue one request, follow it to its ready pulse and release it
  task automatic run_req(input logic [31:0] rs1, input logic [31:0] rs2,
                         input bit chk_mul, input int hold);
    int  cyc;
    int  wcnt;
    int  pulses;
    bit  seen;
    logic [31:0] exp;
    sb.push_back(model(rs1[15:0], rs2[15:0]));
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = C_INSN_OK;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    check("wait_at_accept", 32'(bus.pcpi_wait), 32'd0);
    cyc = 0; wcnt = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (bus.pcpi_ready) begin
        seen = 1'b1;
      end else begin
        if (bus.pcpi_wait) wcnt++;
        if (chk_mul && cyc <= 8) begin
          check("mul_a_step", 32'(mul_a), 32'(exp_ma[cyc-1]));
          check("mul_b_step", 32'(mul_b), 32'(exp_mb[cyc-1]));
        end
        if (cyc == 1) begin
          check("rd_held_busy", bus.pcpi_rd, last_rd);
          bus.pcpi_rs1  = ~rs1;
          bus.pcpi_rs2  = ~rs2;
          bus.pcpi_insn = 32'd0;
        end
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    check("ready_latency", 32'(cyc), 32'd9);
    check("wait_cycles", 32'(wcnt), 32'd8);
    if (seen) begin
      exp = sb.pop_front();
      check("wr_with_ready", 32'(bus.pcpi_wr), 32'd1);
      check("wait_in_done", 32'(bus.pcpi_wait), 32'd0);
      check("mul_a_in_done", 32'(mul_a), 32'd0);
      check("rd_result", bus.pcpi_rd, exp);
      last_rd = exp;
    end
    pulses = 0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (bus.pcpi_ready) pulses++;
    end
    bus.pcpi_valid = 1'b0;
    tick();
    if (bus.pcpi_ready) pulses++;
    check("extra_ready_pulses", 32'(pulses), 32'd0);
    check("rd_held_after", bus.pcpi_rd, last_rd);
  endtask

  // Hold a request the coprocessor must ignore
  task automatic run_ignored(input logic [31:0] insn, input int n);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = 32'h0000_4321;
    bus.pcpi_rs2   = 32'h0000_8765;
    for (int c = 0; c < n; c++) begin
      tick();
      check("ignored_activity",
            {29'd0, bus.pcpi_wait, bus.pcpi_ready, |mul_a}, 32'd0);
    end
    bus.pcpi_valid = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    rst_n          = 1'b0;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = 32'd0;
    bus.pcpi_rs1   = 32'd0;
    bus.pcpi_rs2   = 32'd0;
    tick();
    tick();
    check("rst_wait",  32'(bus.pcpi_wait),  32'd0);
    check("rst_ready", 32'(bus.pcpi_ready), 32'd0);
    check("rst_wr",    32'(bus.pcpi_wr),    32'd0);
    check("rst_rd",    bus.pcpi_rd,         32'd0);
    check("rst_mul",   {24'd0, mul_a, mul_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reference product with per-step multiplier operand checks
    run_req(32'h0000_4321, 32'h0000_8765, 1'b1, 0);
    // All elements saturate
    run_req(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0);
    // Wrong opcode, then wrong funct7: never accepted
    run_ignored(C_INSN_OP, 20);
    run_ignored(C_INSN_F7, 5);

    // Abort at step k=4 with a one-cycle reset
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = C_INSN_OK;
    bus.pcpi_rs1   = 32'h0000_4321;
    bus.pcpi_rs2   = 32'h0000_8765;
    for (int c = 0; c < 5; c++) tick();
    check("abort_wait_k4", 32'(bus.pcpi_wait), 32'd1);
    check("abort_mul_a_k4", 32'(mul_a), 32'd3);
    rst_n          = 1'b0;
    bus.pcpi_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    last_rd = 32'd0;
    check("abort_wait_cleared", 32'(bus.pcpi_wait), 32'd0);
    check("abort_rd_cleared", bus.pcpi_rd, 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.pcpi_ready) pulses++;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    run_req(32'h0000_0001, 32'h0000_0001, 1'b0, 0);

    // Valid held 5 cycles past ready, then an immediate follow-up request
    run_req(32'h0000_4321, 32'h0000_8765, 1'b0, 5);
    run_req(32'hABCD_1234, 32'h5555_00F0, 1'b0, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
